sstv_cal: RTL and testbench

Calibration-header detector sitting directly upstream of the VIS decoder. Consumes the frequency estimate `freq` and recognizes the SSTV calibration header (1900 Hz leader, 1200 Hz break, 1900 Hz leader). On the header-to-VIS-start-bit transition it asserts `cal_ok` to arm the VIS decoder. It holds `cal_ok` until the frame completes or the VIS fails to arrive, then drops it so the VIS decoder returns to idle.

---
 rtl/sstv_cal.sv | 183 ++++++++++++++++++
 tb/tb_sstv_cal.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sstv_cal.sv
// SSTV calibration-header detector: recognises leader / break / leader on a
// millisecond grid and arms the VIS decoder until the frame ends or VIS never shows.
module sstv_cal #(
    parameter int          simulate       = 0,
    parameter logic [11:0] FREQ_TOL       = 12'd50,
    parameter logic [9:0]  LEADER_MIN_MS  = 10'd250,
    parameter logic [9:0]  BREAK_MIN_MS   = 10'd5,
    parameter logic [9:0]  BREAK_MAX_MS   = 10'd20,
    parameter logic [9:0]  GLITCH_MS      = 10'd3,
    parameter logic [9:0]  ARM_TIMEOUT_MS = 10'd400
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] freq,
    input  logic        vis_valid,
    input  logic        frame_done,
    output logic        cal_ok,
    output logic        cal_fail,
    output logic [2:0]  cal_state
);

    localparam int          TICKS_PER_MS = (simulate != 0) ? 100 : 100000;
    localparam logic [16:0] PRESC_LAST   = 17'(TICKS_PER_MS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEADER1 = 3'd1,
        S_BREAK   = 3'd2,
        S_LEADER2 = 3'd3,
        S_ARMED   = 3'd4,
        S_LOCKED  = 3'd5
    } state_t;

    state_t      r_state;
    logic [16:0] r_presc;
    logic [9:0]  r_dur;
    logic [9:0]  r_glitch;
    logic        r_vis_q;
    logic        r_cal_ok;
    logic        r_cal_fail;

    logic        w_tick;
    logic        w_lead;
    logic        w_brk;
    logic        w_vis_rise;
    logic [9:0]  w_dur_inc;
    logic [9:0]  w_glitch_inc;

    // Signed 13-bit distance from the tone centre, compared inclusively against the tolerance.
    function automatic logic in_band(input logic [11:0] f, input logic [11:0] center,
                                     input logic [11:0] tol);
        logic signed [12:0] d;
        logic [12:0]        mag;
        d   = $signed({1'b0, f}) - $signed({1'b0, center});
        mag = d[12] ? $unsigned(-d) : $unsigned(d);
        return (mag <= {1'b0, tol});
    endfunction

    // Tick strobe, tone classes and saturating counter increments.
    always_comb begin
        w_tick       = (r_presc == PRESC_LAST);
        w_lead       = in_band(freq, 12'd1900, FREQ_TOL);
        w_brk        = in_band(freq, 12'd1200, FREQ_TOL);
        w_vis_rise   = vis_valid & ~r_vis_q;
        w_dur_inc    = (r_dur == 10'd1023) ? r_dur : (r_dur + 10'd1);
        w_glitch_inc = r_glitch + 10'd1;
    end

    // Free-running millisecond prescaler.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= 17'd0;
        end else if (w_tick) begin
            r_presc <= 17'd0;
        end else begin
            r_presc <= r_presc + 17'd1;
        end
    end

    // Header FSM; frame_done outranks the VIS edge, which outranks tick-driven exits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_dur      <= 10'd1;
            r_glitch   <= 10'd0;
            r_vis_q    <= 1'b0;
            r_cal_ok   <= 1'b0;
            r_cal_fail <= 1'b0;
        end else begin
            r_vis_q    <= vis_valid;
            r_cal_fail <= 1'b0;
            if (frame_done && (r_state != S_IDLE)) begin
                r_state  <= S_IDLE;
                r_dur    <= 10'd1;
                r_glitch <= 10'd0;
                r_cal_ok <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_tick && w_lead) begin
                            r_state  <= S_LEADER1;
                            r_dur    <= 10'd1;
                            r_glitch <= 10'd0;
                        end
                    end
                    S_LEADER1, S_LEADER2: begin
                        if (w_tick) begin
                            if (w_lead) begin
                                r_dur    <= w_dur_inc;
                                r_glitch <= 10'd0;
                            end else if (w_brk) begin
                                r_dur    <= 10'd1;
                                r_glitch <= 10'd0;
                                if (r_dur >= LEADER_MIN_MS) begin
                                    r_state  <= (r_state == S_LEADER1) ? S_BREAK : S_ARMED;
                                    r_cal_ok <= (r_state == S_LEADER2);
                                end else begin
                                    r_state    <= S_IDLE;
                                    r_cal_fail <= 1'b1;
                                end
                            end else if (w_glitch_inc > GLITCH_MS) begin
                                r_state    <= S_IDLE;
                                r_dur      <= 10'd1;
                                r_glitch   <= 10'd0;
                                r_cal_fail <= 1'b1;
                            end else begin
                                r_glitch <= w_glitch_inc;
                            end
                        end
                    end
                    S_BREAK: begin
                        if (w_tick) begin
                            if (w_brk && (w_dur_inc <= BREAK_MAX_MS)) begin
                                r_dur <= w_dur_inc;
                            end else if (w_lead && (r_dur >= BREAK_MIN_MS)) begin
                                r_state  <= S_LEADER2;
                                r_dur    <= 10'd1;
                                r_glitch <= 10'd0;
                            end else begin
                                r_state    <= S_IDLE;
                                r_dur      <= 10'd1;
                                r_glitch   <= 10'd0;
                                r_cal_fail <= 1'b1;
                            end
                        end
                    end
                    S_ARMED: begin
                        // Only a fresh edge counts: a level left high from the last frame is stale.
                        if (w_vis_rise) begin
                            r_state  <= S_LOCKED;
                            r_dur    <= 10'd1;
                            r_glitch <= 10'd0;
                        end else if (w_tick) begin
                            if (w_dur_inc >= ARM_TIMEOUT_MS) begin
                                r_state    <= S_IDLE;
                                r_dur      <= 10'd1;
                                r_glitch   <= 10'd0;
                                r_cal_ok   <= 1'b0;
                                r_cal_fail <= 1'b1;
                            end else begin
                                r_dur <= w_dur_inc;
                            end
                        end
                    end
                    S_LOCKED: begin
                        r_cal_ok <= 1'b1;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_dur    <= 10'd1;
                        r_glitch <= 10'd0;
                        r_cal_ok <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cal_ok    = r_cal_ok;
    assign cal_fail  = r_cal_fail;
    assign cal_state = r_state;

endmodule

// File: tb/tb_sstv_cal.sv
// Directed bench for sstv_cal: a tone-by-tone header model checked every cycle,
// plus literal state/flag expectations at the end of each stimulus segment.
module tb_sstv_cal;

    localparam int LMIN = 20;
    localparam int TO   = 40;
    localparam int TOL  = 50;
    localparam int BMIN = 5;
    localparam int BMAX = 20;
    localparam int GL   = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] freq;
    logic        vis_valid;
    logic        frame_done;
    logic        cal_ok;
    logic        cal_fail;
    logic [2:0]  cal_state;

    int total = 0;
    int bad   = 0;
    int n_fail = 0;
    int n_okrise = 0;
    int exp_fail = 0;

    sstv_cal #(
        .simulate      (1),
        .LEADER_MIN_MS (10'(LMIN)),
        .ARM_TIMEOUT_MS(10'(TO))
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .freq      (freq),
        .vis_valid (vis_valid),
        .frame_done(frame_done),
        .cal_ok    (cal_ok),
        .cal_fail  (cal_fail),
        .cal_state (cal_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int ph;
        int dur;
        int gl;
        bit ok;
        bit fail;
        bit vq;
    } mst_t;

    mst_t m;
    int   m_cyc;

    function automatic mst_t rst_state();
        mst_t r;
        r = '0;
        r.dur = 1;
        return r;
    endfunction

    // One clock of the header recogniser, phrased tone by tone.
    function automatic mst_t step(input mst_t s, input bit tick, input int f,
                                  input bit vv, input bit fd);
        mst_t n;
        bit lead, brk, go_fail;
        int nxt;
        n = s;
        n.fail = 1'b0;
        n.vq = vv;
        go_fail = 1'b0;
        nxt = -1;
        lead = (f >= 1900 - TOL) && (f <= 1900 + TOL);
        brk  = (f >= 1200 - TOL) && (f <= 1200 + TOL);
        if (fd && s.ph != 0) nxt = 0;
        else if (s.ph == 4 && vv && !s.vq) nxt = 5;
        else if (tick) begin
            case (s.ph)
                0: if (lead) nxt = 1;
                1, 3: begin
                    if (lead) begin
                        n.dur = (s.dur < 1023) ? s.dur + 1 : 1023;
                        n.gl = 0;
                    end else if (brk) begin
                        if (s.dur >= LMIN) nxt = (s.ph == 1) ? 2 : 4;
                        else go_fail = 1'b1;
                    end else if (s.gl + 1 > GL) go_fail = 1'b1;
                    else n.gl = s.gl + 1;
                end
                2: begin
                    if (brk && s.dur + 1 <= BMAX) n.dur = s.dur + 1;
                    else if (lead && s.dur >= BMIN) nxt = 3;
                    else go_fail = 1'b1;
                end
                4: begin
                    if (s.dur + 1 >= TO) go_fail = 1'b1;
                    else n.dur = s.dur + 1;
                end
                default: ;
            endcase
        end
        if (go_fail) begin
            nxt = 0;
            n.fail = 1'b1;
        end
        if (nxt >= 0) begin
            n.ph = nxt;
            n.dur = 1;
            n.gl = 0;
        end
        n.ok = (n.ph == 4) || (n.ph == 5);
        return n;
    endfunction

    // Reference model advances on the same edges as the design.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m     <= rst_state();
            m_cyc <= 0;
        end else begin
            m     <= step(m, (m_cyc % 100) == 99, int'(freq), vis_valid, frame_done);
            m_cyc <= m_cyc + 1;
        end
    end

    always @(posedge cal_fail) n_fail <= n_fail + 1;
    always @(posedge cal_ok)   n_okrise <= n_okrise + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cycle", 16'({cal_ok, cal_fail, cal_state}),
            16'({m.ok, m.fail, 3'(m.ph)}));
    end

    task automatic seg(input int f, input int n_ms);
        freq = 12'(f);
        repeat (n_ms * 100) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_st(input string name, input int st, input bit ok);
        chk(name, 16'(cal_state), 16'(st));
        chk({name, "_ok"}, 16'(cal_ok), 16'(ok));
        chk({name, "_model"}, 16'(m.ph), 16'(st));
    endtask

    task automatic expect_fails(input string name);
        chk(name, 16'(n_fail), 16'(exp_fail));
    endtask

    task automatic pulse_fd();
        frame_done = 1'b1;
        @(posedge clk);
        #1;
        frame_done = 1'b0;
    endtask

    task automatic header(input int brk_f, input int lead2_f);
        seg(1900, 25);
        seg(brk_f, 10);
        seg(lead2_f, 25);
        seg(1200, 1);
    endtask

    initial begin
        reset_n    = 1'b0;
        freq       = 12'd0;
        vis_valid  = 1'b0;
        frame_done = 1'b0;
        #3;
        expect_st("reset", 0, 1'b0);
        chk("reset_fail", 16'(cal_fail), 16'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        seg(0, 2);

        // Nominal header, lock on VIS edge, release on frame_done.
        seg(1900, 25);
        expect_st("nom_l1", 1, 1'b0);
        seg(1200, 10);
        expect_st("nom_brk", 2, 1'b0);
        seg(1900, 25);
        expect_st("nom_l2", 3, 1'b0);
        seg(1200, 1);
        expect_st("nom_armed", 4, 1'b1);
        chk("nom_okrise", 16'(n_okrise), 16'd1);
        vis_valid = 1'b1;
        @(posedge clk);
        #1;
        vis_valid = 1'b0;
        expect_st("nom_locked", 5, 1'b1);
        seg(0, 2);
        expect_st("nom_hold", 5, 1'b1);
        pulse_fd();
        expect_st("nom_done", 0, 1'b0);
        seg(0, 1);
        expect_fails("nom_nofail");

        // Short leader.
        seg(1900, 10);
        seg(1200, 1);
        exp_fail++;
        expect_st("short", 0, 1'b0);
        expect_fails("short_fail");
        seg(0, 1);

        // Three off-band ms inside leader 1 are tolerated.
        seg(1900, 10);
        seg(1500, 3);
        seg(1900, 15);
        expect_st("glitch3_l1", 1, 1'b0);
        seg(1200, 10);
        seg(1900, 25);
        seg(1200, 1);
        expect_st("glitch3_armed", 4, 1'b1);
        pulse_fd();
        expect_fails("glitch3_nofail");

        // Four off-band ms abort.
        seg(1900, 10);
        seg(1500, 3);
        expect_st("glitch4_pre", 1, 1'b0);
        seg(1500, 1);
        exp_fail++;
        expect_st("glitch4", 0, 1'b0);
        expect_fails("glitch4_fail");
        seg(0, 1);

        // Break too short.
        seg(1900, 25);
        seg(1200, 4);
        expect_st("brk4_pre", 2, 1'b0);
        seg(1900, 1);
        exp_fail++;
        expect_st("brk4", 0, 1'b0);
        expect_fails("brk4_fail");
        seg(0, 1);

        // Break too long: the 21st break ms aborts.
        seg(1900, 25);
        seg(1200, 20);
        expect_st("brk21_pre", 2, 1'b0);
        seg(1200, 1);
        exp_fail++;
        expect_st("brk21", 0, 1'b0);
        expect_fails("brk21_fail");
        seg(0, 1);

        // Tones at the tolerance edge: 1150 Hz break, 1950 Hz leader.
        header(1150, 1950);
        expect_st("tol_armed", 4, 1'b1);
        pulse_fd();
        expect_st("tol_done", 0, 1'b0);
        expect_fails("tol_nofail");
        seg(0, 1);

        // Stale vis_valid: no lock, timeout when the ms count reaches TO.
        vis_valid = 1'b1;
        header(1200, 1900);
        expect_st("stale_armed", 4, 1'b1);
        seg(0, TO - 2);
        expect_st("stale_wait", 4, 1'b1);
        seg(0, 1);
        exp_fail++;
        expect_st("timeout", 0, 1'b0);
        expect_fails("timeout_fail");
        vis_valid = 1'b0;
        seg(0, 1);

        // frame_done beats a simultaneous VIS edge.
        header(1200, 1900);
        expect_st("prio_armed", 4, 1'b1);
        vis_valid  = 1'b1;
        frame_done = 1'b1;
        @(posedge clk);
        #1;
        vis_valid  = 1'b0;
        frame_done = 1'b0;
        expect_st("prio", 0, 1'b0);
        expect_fails("prio_nofail");
        seg(0, 1);

        // Asynchronous reset mid-header.
        seg(1900, 25);
        seg(1200, 10);
        seg(1900, 5);
        expect_st("rst_l2", 3, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("rst_async", 16'({cal_ok, cal_fail, cal_state}), 16'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        seg(0, 2);
        expect_st("rst_after", 0, 1'b0);
        expect_fails("rst_nofail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
